dragon_length_ctrl: RTL and testbench

Per-frame length arbiter for the dragon enemy. Snapshots the head and the seven body segment registers plus their display enables on each frame, scans them serially against the player's sword and against the head (self-collision), and issues the one-cycle `lengthUpdate` pulse (HEAL/HIT) that the dragon body queue consumes. Sits between the game-logic event sources and the dragon body block and is the sole driver of `lengthUpdate`.

---
 rtl/dragon_length_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_dragon_length_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dragon_length_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dragon_length_ctrl
//  Description : Per-frame length arbiter for the dragon enemy. Snapshots the
//                head, the seven body segments and their enables on each
//                frame. It scans them serially against the sword and against
//                the head, then issues a single HEAL/HIT pulse on
//                lengthUpdate.
//  Revision    : 1.0 - initial release
// ============================================================================
module dragon_length_ctrl #(
   parameter int COOLDOWN_FRAMES = 30
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       vsync,
   input  logic [9:0] Dragon_Head,
   input  logic [9:0] Dragon_1,
   input  logic [9:0] Dragon_2,
   input  logic [9:0] Dragon_3,
   input  logic [9:0] Dragon_4,
   input  logic [9:0] Dragon_5,
   input  logic [9:0] Dragon_6,
   input  logic [9:0] Dragon_7,
   input  logic [6:0] Display_en,
   input  logic       sword_active,
   input  logic [7:0] sword_pos,
   input  logic       heal_event,
   output logic [1:0] lengthUpdate,
   output logic       self_hit,
   output logic [2:0] hit_index,
   output logic       dragon_dead,
   output logic       busy
);

   localparam int CW = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
   localparam logic [CW-1:0] C_COOL_LOAD = CW'(COOLDOWN_FRAMES);

   localparam logic [1:0] C_IDLE  = 2'd0;
   localparam logic [1:0] C_SNAP  = 2'd1;
   localparam logic [1:0] C_SCAN  = 2'd2;
   localparam logic [1:0] C_ISSUE = 2'd3;

   localparam logic [1:0] C_LU_NONE = 2'b00;
   localparam logic [1:0] C_LU_HEAL = 2'b01;
   localparam logic [1:0] C_LU_HIT  = 2'b10;

   logic [1:0]    state_q, state_d;
   logic          vs_q, vs_prev_q;
   logic [7:0]    pos_q [0:7];
   logic [6:0]    en_q;
   logic          sact_q;
   logic [7:0]    spos_q;
   logic [2:0]    scan_q;
   logic          sword_hit_q, sword_hit_d;
   logic          self_flag_q, self_flag_d;
   logic [2:0]    idx_q, idx_d;
   logic [2:0]    self_idx_q, self_idx_d;
   logic          heal_pend_q;
   logic          blk_q;
   logic [CW-1:0] cool_q;
   logic [1:0]    lu_q;
   logic          dead_q;
   logic          self_hit_q;
   logic [2:0]    hit_idx_q;

   logic [7:0]    w_pos_in [0:7];
   logic [7:0]    w_en_all;
   logic          w_en_cur;
   logic [7:0]    w_pos_cur;
   logic          w_rise;
   logic          w_start;
   logic          w_sword_m;
   logic          w_self_m;
   logic          w_last;
   logic          w_strike;
   logic          w_do_hit;
   logic          w_do_dead;
   logic          w_heal_take;
   logic          w_do_heal;
   logic          w_unused;

   // Orientation bits are not needed for tile comparisons
   assign w_unused = ^{Dragon_Head[9:8], Dragon_1[9:8], Dragon_2[9:8], Dragon_3[9:8],
                       Dragon_4[9:8], Dragon_5[9:8], Dragon_6[9:8], Dragon_7[9:8]};

   // Slot 0 is the head, slots 1..7 are the body segments
   assign w_pos_in[0] = Dragon_Head[7:0];
   assign w_pos_in[1] = Dragon_1[7:0];
   assign w_pos_in[2] = Dragon_2[7:0];
   assign w_pos_in[3] = Dragon_3[7:0];
   assign w_pos_in[4] = Dragon_4[7:0];
   assign w_pos_in[5] = Dragon_5[7:0];
   assign w_pos_in[6] = Dragon_6[7:0];
   assign w_pos_in[7] = Dragon_7[7:0];

   // Head is always present, so it gets a constant enable in slot 0
   assign w_en_all  = {en_q, 1'b1};
   assign w_en_cur  = w_en_all[scan_q];
   assign w_pos_cur = pos_q[scan_q];

   assign w_rise  = vs_q & ~vs_prev_q;
   assign w_start = (state_q == C_IDLE) & w_rise;

   // One comparison per scan slot; the self test starts at segment 2
   always_comb begin
      w_sword_m   = (state_q == C_SCAN) & w_en_cur & sact_q & (spos_q == w_pos_cur);
      w_self_m    = (state_q == C_SCAN) & w_en_cur & (scan_q >= 3'd2) & (pos_q[0] == w_pos_cur);
      sword_hit_d = sword_hit_q | w_sword_m;
      self_flag_d = self_flag_q | w_self_m;
      idx_d       = (w_sword_m & ~sword_hit_q) ? scan_q : idx_q;
      self_idx_d  = (w_self_m & ~self_flag_q) ? scan_q : self_idx_q;
   end

   // The decision is taken on the last scan slot so that the registered
   // outputs are already valid during the ISSUE cycle
   always_comb begin
      w_last      = (state_q == C_SCAN) & (scan_q == 3'd7);
      w_strike    = w_last & (sword_hit_d | self_flag_d) & ~blk_q;
      w_do_hit    = w_strike & (en_q != 7'h00);
      w_do_dead   = w_strike & (en_q == 7'h00) & sword_hit_d & (idx_d == 3'd0);
      w_heal_take = w_last & ~w_strike & heal_pend_q;
      w_do_heal   = w_heal_take & (en_q != 7'h7F);
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!reset) state_q <= C_IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         C_IDLE:  if (w_start) state_d = C_SNAP;
         C_SNAP:  state_d = C_SCAN;
         C_SCAN:  if (scan_q == 3'd7) state_d = C_ISSUE;
         C_ISSUE: state_d = C_IDLE;
         default: state_d = C_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy         = (state_q != C_IDLE);
      lengthUpdate = lu_q;
      dragon_dead  = dead_q;
      self_hit     = self_hit_q;
      hit_index    = hit_idx_q;
   end

   // vsync edge detector
   always_ff @(posedge clk) begin
      if (!reset) begin
         vs_q      <= 1'b0;
         vs_prev_q <= 1'b0;
      end else begin
         vs_q      <= vsync;
         vs_prev_q <= vs_q;
      end
   end

   // Frame snapshot of positions, enables and sword
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int k = 0; k < 8; k++) pos_q[k] <= 8'h00;
         en_q   <= 7'h00;
         sact_q <= 1'b0;
         spos_q <= 8'h00;
      end else if (state_q == C_SNAP) begin
         for (int k = 0; k < 8; k++) pos_q[k] <= w_pos_in[k];
         en_q   <= Display_en;
         sact_q <= sword_active;
         spos_q <= sword_pos;
      end
   end

   // Scan index and accumulated match flags
   always_ff @(posedge clk) begin
      if (!reset) begin
         scan_q      <= 3'd0;
         sword_hit_q <= 1'b0;
         self_flag_q <= 1'b0;
         idx_q       <= 3'd0;
         self_idx_q  <= 3'd0;
      end else if (state_q == C_SNAP) begin
         scan_q      <= 3'd0;
         sword_hit_q <= 1'b0;
         self_flag_q <= 1'b0;
         idx_q       <= 3'd0;
         self_idx_q  <= 3'd0;
      end else if (state_q == C_SCAN) begin
         scan_q      <= scan_q + 3'd1;
         sword_hit_q <= sword_hit_d;
         self_flag_q <= self_flag_d;
         idx_q       <= idx_d;
         self_idx_q  <= self_idx_d;
      end
   end

   // Heal request latch; a new request wins over the clear in the same cycle
   always_ff @(posedge clk) begin
      if (!reset)          heal_pend_q <= 1'b0;
      else if (heal_event) heal_pend_q <= 1'b1;
      else if (w_heal_take) heal_pend_q <= 1'b0;
   end

   // Cooldown: a frame is suppressed when the counter was still running at
   // the vsync edge that started it, so exactly COOLDOWN_FRAMES frames are
   // skipped after a HIT
   always_ff @(posedge clk) begin
      if (!reset) begin
         cool_q <= '0;
         blk_q  <= 1'b0;
      end else begin
         if (w_do_hit)                       cool_q <= C_COOL_LOAD;
         else if (w_rise && (cool_q != '0))  cool_q <= cool_q - 1'b1;
         if (w_start) blk_q <= (cool_q != '0);
      end
   end

   // Registered result pulses and the sticky last-hit information
   always_ff @(posedge clk) begin
      if (!reset) begin
         lu_q       <= C_LU_NONE;
         dead_q     <= 1'b0;
         self_hit_q <= 1'b0;
         hit_idx_q  <= 3'd0;
      end else begin
         lu_q   <= w_do_hit ? C_LU_HIT : (w_do_heal ? C_LU_HEAL : C_LU_NONE);
         dead_q <= w_do_dead;
         if (w_do_hit) begin
            // A sword strike takes precedence over a simultaneous self hit
            self_hit_q <= ~sword_hit_d;
            hit_idx_q  <= sword_hit_d ? idx_d : self_idx_d;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dragon_length_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dragon_length_ctrl
//  Description : Scoreboard bench for dragon_length_ctrl. The stimulus
//                process queues each expected pulse with its cycle, and the
//                monitor checks every pulse the DUT produces.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dragon_length_ctrl;

   typedef struct {
      logic [1:0] lu;
      logic       dead;
      logic       sh;
      logic [2:0] idx;
      int         cyc;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       vsync;
   logic [9:0] Dragon_Head;
   logic [9:0] Dragon_1, Dragon_2, Dragon_3, Dragon_4, Dragon_5, Dragon_6, Dragon_7;
   logic [6:0] Display_en;
   logic       sword_active;
   logic [7:0] sword_pos;
   logic       heal_event;
   logic [1:0] lengthUpdate;
   logic       self_hit;
   logic [2:0] hit_index;
   logic       dragon_dead;
   logic       busy;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   exp_t sb [$];
   exp_t mon_e;

   dragon_length_ctrl #(.COOLDOWN_FRAMES(30)) dut (
      .clk          (clk),
      .reset        (reset),
      .vsync        (vsync),
      .Dragon_Head  (Dragon_Head),
      .Dragon_1     (Dragon_1),
      .Dragon_2     (Dragon_2),
      .Dragon_3     (Dragon_3),
      .Dragon_4     (Dragon_4),
      .Dragon_5     (Dragon_5),
      .Dragon_6     (Dragon_6),
      .Dragon_7     (Dragon_7),
      .Display_en   (Display_en),
      .sword_active (sword_active),
      .sword_pos    (sword_pos),
      .heal_event   (heal_event),
      .lengthUpdate (lengthUpdate),
      .self_hit     (self_hit),
      .hit_index    (hit_index),
      .dragon_dead  (dragon_dead),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every pulse must match the head of the scoreboard
   always @(negedge clk) begin
      if (lengthUpdate != 2'b00 || dragon_dead) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pulse: got lu=%b dead=%b at cyc %0d, required no pulse",
                     lengthUpdate, dragon_dead, cyc);
         end else begin
            mon_e = sb.pop_front();
            if (lengthUpdate != mon_e.lu || dragon_dead != mon_e.dead || self_hit != mon_e.sh ||
                hit_index != mon_e.idx || cyc != mon_e.cyc) begin
               failures++;
               $display("FAIL pulse: got lu=%b dead=%b sh=%b idx=%0d cyc=%0d, required lu=%b dead=%b sh=%b idx=%0d cyc=%0d",
                        lengthUpdate, dragon_dead, self_hit, hit_index, cyc,
                        mon_e.lu, mon_e.dead, mon_e.sh, mon_e.idx, mon_e.cyc);
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   task automatic set_defaults();
      Dragon_Head  = {2'b00, 8'h01};
      Dragon_1     = {2'b01, 8'h11};
      Dragon_2     = {2'b10, 8'h21};
      Dragon_3     = {2'b11, 8'h31};
      Dragon_4     = {2'b00, 8'h41};
      Dragon_5     = {2'b01, 8'h51};
      Dragon_6     = {2'b10, 8'h61};
      Dragon_7     = {2'b11, 8'h71};
      Display_en   = 7'h00;
      sword_active = 1'b0;
      sword_pos    = 8'h00;
   endtask

   task automatic do_reset(input bool_check);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         vsync = ~vsync;
         @(negedge clk);
         if (bool_check) begin
            chk("reset_outputs", {lengthUpdate, self_hit, hit_index, dragon_dead}, 0);
            chk("reset_busy", busy, 0);
         end
      end
      vsync = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic pulse_heal();
      @(negedge clk);
      heal_event = 1'b1;
      @(negedge clk);
      heal_event = 1'b0;
   endtask

   // One frame: vsync rises at edge E = c+1, the pulse is seen after E+10
   task automatic frame(input bit exp_p, input logic [1:0] lu, input logic dead,
                        input logic sh, input logic [2:0] idx, input bit heal_at_issue);
      int c;
      exp_t e;
      @(negedge clk);
      c = cyc;
      vsync = 1'b1;
      if (exp_p) begin
         e.lu = lu; e.dead = dead; e.sh = sh; e.idx = idx; e.cyc = c + 11;
         sb.push_back(e);
      end
      repeat (3) @(negedge clk);
      vsync = 1'b0;
      chk("busy_in_scan", busy, 1);
      repeat (7) @(negedge clk);
      if (heal_at_issue) heal_event = 1'b1;
      @(negedge clk);
      heal_event = 1'b0;
      repeat (3) @(negedge clk);
      chk("busy_after_frame", busy, 0);
   endtask

   initial begin
      reset      = 1'b0;
      vsync      = 1'b0;
      heal_event = 1'b0;
      set_defaults();

      // Reset with vsync toggling
      do_reset(1'b1);

      // Heal with room to grow
      Display_en = 7'h03;
      pulse_heal();
      frame(1'b1, 2'b01, 1'b0, 1'b0, 3'd0, 1'b0);

      // Heal while full: no pulse, and the request is consumed
      Display_en = 7'h7F;
      pulse_heal();
      frame(1'b0, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0);
      Display_en = 7'h03;
      frame(1'b0, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0);

      // Two requests collapse into one heal
      pulse_heal();
      pulse_heal();
      frame(1'b1, 2'b01, 1'b0, 1'b0, 3'd0, 1'b0);
      frame(1'b0, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0);

      // Request arriving as ISSUE consumes the previous one is kept
      pulse_heal();
      frame(1'b1, 2'b01, 1'b0, 1'b0, 3'd0, 1'b1);
      frame(1'b1, 2'b01, 1'b0, 1'b0, 3'd0, 1'b0);

      // Sword hit on segment 2, then cooldown for 30 frames, HIT on the 31st
      Display_en   = 7'h07;
      Dragon_2     = {2'b00, 8'h35};
      sword_active = 1'b1;
      sword_pos    = 8'h35;
      frame(1'b1, 2'b10, 1'b0, 1'b0, 3'd2, 1'b0);
      for (int f = 0; f < 30; f++) frame(1'b0, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0);
      frame(1'b1, 2'b10, 1'b0, 1'b0, 3'd2, 1'b0);
      chk("hit_index_held", hit_index, 2);

      // Self-collision on segment 4
      do_reset(1'b0);
      set_defaults();
      Dragon_Head = {2'b00, 8'h44};
      Dragon_4    = {2'b01, 8'h44};
      Display_en  = 7'h0F;
      frame(1'b1, 2'b10, 1'b0, 1'b1, 3'd4, 1'b0);
      chk("self_hit_held", self_hit, 1);

      // Same geometry with segment 4 disabled
      do_reset(1'b0);
      Display_en = 7'h07;
      frame(1'b0, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0);

      // HIT beats heal, heal goes through on the cooled-down frame
      do_reset(1'b0);
      set_defaults();
      Display_en   = 7'h07;
      Dragon_2     = {2'b00, 8'h35};
      sword_active = 1'b1;
      sword_pos    = 8'h35;
      pulse_heal();
      frame(1'b1, 2'b10, 1'b0, 1'b0, 3'd2, 1'b0);
      frame(1'b1, 2'b01, 1'b0, 1'b0, 3'd2, 1'b0);
      frame(1'b0, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0);

      // Head struck with no body left
      do_reset(1'b0);
      set_defaults();
      Dragon_Head  = {2'b10, 8'h12};
      sword_active = 1'b1;
      sword_pos    = 8'h12;
      frame(1'b1, 2'b00, 1'b1, 1'b0, 3'd0, 1'b0);

      // Reset in the middle of SCAN aborts the frame
      do_reset(1'b0);
      set_defaults();
      Display_en   = 7'h07;
      Dragon_2     = {2'b00, 8'h35};
      sword_active = 1'b1;
      sword_pos    = 8'h35;
      @(negedge clk);
      vsync = 1'b1;
      repeat (3) @(negedge clk);
      vsync = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      reset = 1'b1;
      repeat (14) @(negedge clk);

      chk("missing_pulses", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
